// File: rtl/fifo_multi_port.sv
// fifo_multi_port: multi-lane decoupling FIFO between fetch/decode and dispatch.
// Accepts up to ENQ_LANES entries and releases up to DEQ_LANES entries per cycle.
// Occupancy is the difference of two wrap-bit counters. The MSB tells full from
// empty, so every storage slot is usable.
module fifo_multi_port #(
  parameter int DATA_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 16,
  parameter int ENQ_LANES    = 2,
  parameter int DEQ_LANES    = 2,
  parameter int AFULL_THRESH = 12
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            flush_i,
  input  logic [ENQ_LANES-1:0]            valid_enq_i,
  input  logic [ENQ_LANES*DATA_WIDTH-1:0] data_enq_i,
  output logic                            ready_enq_o,
  input  logic [DEQ_LANES-1:0]            ready_deq_i,
  output logic [DEQ_LANES-1:0]            valid_deq_o,
  output logic [DEQ_LANES*DATA_WIDTH-1:0] data_deq_o,
  output logic [$clog2(FIFO_DEPTH):0]     count_o,
  output logic                            almost_full_o
);

  localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);
  localparam int CTR_WIDTH = PTR_WIDTH + 1;

  localparam logic [CTR_WIDTH-1:0] DEPTH_C = CTR_WIDTH'(FIFO_DEPTH);
  localparam logic [CTR_WIDTH-1:0] ENQ_C   = CTR_WIDTH'(ENQ_LANES);
  localparam logic [CTR_WIDTH-1:0] AFULL_C = CTR_WIDTH'(AFULL_THRESH);
  localparam logic [CTR_WIDTH-1:0] ONE_C   = CTR_WIDTH'(1);

  logic [CTR_WIDTH-1:0]  enqCtr_q, enqCtr_d;
  logic [CTR_WIDTH-1:0]  deqCtr_q, deqCtr_d;
  logic [DATA_WIDTH-1:0] storage_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] storage_d [FIFO_DEPTH];

  logic [CTR_WIDTH-1:0]  occupancy;
  logic [CTR_WIDTH-1:0]  freeSlots;
  logic                  readyEnq;
  logic [CTR_WIDTH-1:0]  pushes;
  logic [CTR_WIDTH-1:0]  pops;
  logic [PTR_WIDTH-1:0]  enqPtr;
  logic [PTR_WIDTH-1:0]  deqPtr;
  logic [DEQ_LANES-1:0]  validDeq;

  // Occupancy, free space and status flags, all from registered counters only.
  always_comb begin
    enqPtr    = enqCtr_q[PTR_WIDTH-1:0];
    deqPtr    = deqCtr_q[PTR_WIDTH-1:0];
    occupancy = enqCtr_q - deqCtr_q;
    freeSlots = DEPTH_C - occupancy;
    readyEnq  = (freeSlots >= ENQ_C);
  end

  // Enqueue count: the contiguous run of valid lanes from lane 0, all-or-nothing on ready.
  always_comb begin : pushRunBlk
    logic pushRun;
    pushes  = '0;
    pushRun = readyEnq;
    for (int j = 0; j < ENQ_LANES; j++) begin
      if (pushRun && valid_enq_i[j]) begin
        pushes = pushes + ONE_C;
      end else begin
        pushRun = 1'b0;
      end
    end
  end

  // Dequeue view: lane i presents the i-th oldest slot; valid while occupancy exceeds i.
  always_comb begin : deqViewBlk
    logic [PTR_WIDTH-1:0] rdIdx;
    validDeq   = '0;
    data_deq_o = '0;
    rdIdx      = '0;
    for (int i = 0; i < DEQ_LANES; i++) begin
      rdIdx       = deqPtr + PTR_WIDTH'(i);
      validDeq[i] = (occupancy > CTR_WIDTH'(i));
      data_deq_o[i*DATA_WIDTH +: DATA_WIDTH] = storage_q[rdIdx];
    end
  end

  // Dequeue count: the contiguous run of lanes that are both valid and ready, from lane 0.
  always_comb begin : popRunBlk
    logic popRun;
    pops   = '0;
    popRun = 1'b1;
    for (int i = 0; i < DEQ_LANES; i++) begin
      if (popRun && validDeq[i] && ready_deq_i[i]) begin
        pops = pops + ONE_C;
      end else begin
        popRun = 1'b0;
      end
    end
  end

  // Storage write: accepted lanes land at consecutive slots after the enqueue pointer.
  always_comb begin : storageWrBlk
    logic [PTR_WIDTH-1:0] wrIdx;
    storage_d = storage_q;
    wrIdx     = '0;
    if (!flush_i) begin
      for (int j = 0; j < ENQ_LANES; j++) begin
        wrIdx = enqPtr + PTR_WIDTH'(j);
        if (CTR_WIDTH'(j) < pushes) begin
          storage_d[wrIdx] = data_enq_i[j*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // Counter update: flush empties the FIFO by catching the read side up and drops this cycle's traffic.
  always_comb begin
    enqCtr_d = enqCtr_q + pushes;
    deqCtr_d = deqCtr_q + pops;
    if (flush_i) begin
      enqCtr_d = enqCtr_q;
      deqCtr_d = enqCtr_q;
    end
  end

  // State register with synchronous reset clearing both counters and every slot.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      enqCtr_q <= '0;
      deqCtr_q <= '0;
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        storage_q[k] <= '0;
      end
    end else begin
      enqCtr_q <= enqCtr_d;
      deqCtr_q <= deqCtr_d;
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        storage_q[k] <= storage_d[k];
      end
    end
  end

  // Output drive.
  always_comb begin
    ready_enq_o   = readyEnq;
    valid_deq_o   = validDeq;
    count_o       = occupancy;
    almost_full_o = (occupancy >= AFULL_C);
  end

endmodule
